// File: rtl/transit_timer.sv
// transit_timer: measures the time from an ALU start request to the next
// rising edge of an asynchronous gate sensor, in ticks of PRESCALE clocks.
// The result is presented on timer with enable_transit as the completion flag.
module transit_timer #(
    parameter int unsigned PRESCALE    = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        sensor_in,
    output logic [15:0] timer,
    output logic        enable_transit,
    output logic        busy,
    output logic        timeout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [1:0]             state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sens_prev;
    logic                   sens_rise;
    logic [15:0]            presc;
    logic [15:0]            count;
    logic                   timeout_q;

    // Bring the raw sensor into the clock domain and keep one delayed copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= '0;
            sens_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sensor_in};
            sens_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sens_rise = sync_q[SYNC_STAGES-1] & ~sens_prev;

    // Measurement sequencer: start always re-arms; RUN ends on a sensor edge or saturation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            presc     <= '0;
            count     <= '0;
            timeout_q <= 1'b0;
        end else if (start) begin
            state     <= ST_ARM;
            presc     <= '0;
            count     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_IDLE;
                // One settling cycle so a sensor already high is not seen as an edge
                ST_ARM:  state <= ST_RUN;
                ST_RUN: begin
                    if (sens_rise) begin
                        // A tick landing on the same edge as the sensor is dropped
                        state     <= ST_DONE;
                        timeout_q <= 1'b0;
                    end else if (presc == PRESC_LAST) begin
                        presc <= '0;
                        if (count == '1) begin
                            state     <= ST_DONE;
                            timeout_q <= 1'b1;
                        end else begin
                            count <= count + 16'd1;
                        end
                    end else begin
                        presc <= presc + 16'd1;
                    end
                end
                ST_DONE: state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign timer          = count;
    assign timeout        = timeout_q;
    assign enable_transit = (state == ST_DONE);
    assign busy           = (state == ST_ARM) || (state == ST_RUN);

endmodule

// File: tb/tb_transit_timer.sv
// tb_transit_timer: randomized self-checking bench for transit_timer.
// Two instances: PRESCALE=4 for timing scenarios, PRESCALE=2 for saturation.
module tb_transit_timer;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start4, sensor4, start2, sensor2;
    logic [15:0] timer4, timer2;
    logic        en4, busy4, to4;
    logic        en2, busy2, to2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    transit_timer #(.PRESCALE(4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .sensor_in(sensor4),
        .timer(timer4), .enable_transit(en4), .busy(busy4), .timeout(to4)
    );

    transit_timer #(.PRESCALE(2), .SYNC_STAGES(S)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .sensor_in(sensor2),
        .timer(timer2), .enable_transit(en2), .busy(busy2), .timeout(to2)
    );

    // Reference model: ticks accumulated after n clock edges in RUN, saturating.
    function automatic int unsigned model_ticks(input int unsigned n, input int unsigned p);
        int unsigned t;
        t = n / p;
        return (t > 65535) ? 65535 : t;
    endfunction

    // Reference model: pin raised after RUN edge k is seen at edge k+S+1,
    // so only edges up to k+S contribute ticks.
    function automatic int unsigned model_result(input int unsigned k, input int unsigned p);
        return model_ticks(k + S, p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start4 = 1'b0; sensor4 = 1'b0; start2 = 1'b0; sensor2 = 1'b0;
        steps(3);
        checks++;
        if (timer4 !== 16'd0 || en4 !== 1'b0 || busy4 !== 1'b0 || to4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: timer=%0d en=%b busy=%b timeout=%b, expected 0 0 0 0",
                     timer4, en4, busy4, to4);
        end
        reset_n = 1'b1;
        step();
        start4 = 1'b1; step(); start4 = 1'b0; step();
        steps(29);
        checks++;
        if (timer4 !== 16'(model_ticks(29, 4)) || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: timer=%0d busy=%b, expected timer=%0d busy=1",
                     timer4, busy4, model_ticks(29, 4));
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (timer4 !== 16'd0 || en4 !== 1'b0 || busy4 !== 1'b0 || to4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: timer=%0d en=%b busy=%b timeout=%b, expected 0 0 0 0",
                     timer4, en4, busy4, to4);
        end
        step();
        reset_n = 1'b1;
        steps(3);
        checks++;
        if (timer4 !== 16'd0 || en4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: timer=%0d en=%b busy=%b, expected 0 0 0",
                     timer4, en4, busy4);
        end
    endtask

    task automatic test_measurement();
        int unsigned k, probe, exp_t;
        for (int it = 0; it < 7; it++) begin
            k     = (it == 0) ? 41 : $urandom_range(120, 0);
            probe = (k > 0) ? $urandom_range(k, 1) : 0;
            exp_t = model_result(k, 4);
            sensor4 = 1'b0;
            steps(S + 2);
            start4 = 1'b1; step(); start4 = 1'b0;
            if (it > 0) begin
                checks++;
                if (en4 !== 1'b0 || busy4 !== 1'b1 || timer4 !== 16'd0 || to4 !== 1'b0) begin
                    errors++;
                    $display("FAIL rearm_from_done[%0d]: en=%b busy=%b timer=%0d timeout=%b, expected 0 1 0 0",
                             it, en4, busy4, timer4, to4);
                end
            end
            step();
            for (int unsigned n = 1; n <= k; n++) begin
                step();
                if (n == probe) begin
                    checks++;
                    if (timer4 !== 16'(model_ticks(n, 4)) || busy4 !== 1'b1 || en4 !== 1'b0) begin
                        errors++;
                        $display("FAIL live_count[%0d]: n=%0d timer=%0d busy=%b en=%b, expected timer=%0d busy=1 en=0",
                                 it, n, timer4, busy4, en4, model_ticks(n, 4));
                    end
                end
            end
            sensor4 = 1'b1;
            steps(S);
            checks++;
            if (en4 !== 1'b0 || busy4 !== 1'b1) begin
                errors++;
                $display("FAIL done_early[%0d]: en=%b busy=%b, expected en=0 busy=1", it, en4, busy4);
            end
            step();
            checks++;
            if (en4 !== 1'b1 || busy4 !== 1'b0 || to4 !== 1'b0 || timer4 !== 16'(exp_t)) begin
                errors++;
                $display("FAIL meas_done[%0d]: k=%0d timer=%0d en=%b busy=%b timeout=%b, expected timer=%0d en=1 busy=0 timeout=0",
                         it, k, timer4, en4, busy4, to4, exp_t);
            end
            if (it == 0) begin
                steps(20);
                checks++;
                if (timer4 !== 16'd10 || en4 !== 1'b1) begin
                    errors++;
                    $display("FAIL meas_hold: timer=%0d en=%b, expected timer=10 en=1", timer4, en4);
                end
            end
        end
    endtask

    task automatic test_sensor_high();
        bit early;
        early = 1'b0;
        sensor4 = 1'b1;
        steps(S + 3);
        start4 = 1'b1; step(); start4 = 1'b0; step();
        for (int unsigned n = 1; n <= 40; n++) begin
            step();
            if (en4 !== 1'b0) early = 1'b1;
            if (n == 10) sensor4 = 1'b0;
        end
        checks++;
        if (early || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL level_ignored: early_done=%b busy=%b, expected early_done=0 busy=1", early, busy4);
        end
        sensor4 = 1'b1;
        steps(S + 1);
        checks++;
        if (en4 !== 1'b1 || to4 !== 1'b0 || timer4 !== 16'(model_result(40, 4))) begin
            errors++;
            $display("FAIL second_rise: timer=%0d en=%b timeout=%b, expected timer=%0d en=1 timeout=0",
                     timer4, en4, to4, model_result(40, 4));
        end
    endtask

    task automatic test_restart();
        int unsigned k;
        sensor4 = 1'b0;
        steps(S + 2);
        start4 = 1'b1; step(); start4 = 1'b0; step();
        steps(25);
        checks++;
        if (timer4 !== 16'(model_ticks(25, 4))) begin
            errors++;
            $display("FAIL restart_pre: timer=%0d, expected %0d", timer4, model_ticks(25, 4));
        end
        start4 = 1'b1; step(); start4 = 1'b0;
        checks++;
        if (timer4 !== 16'd0 || busy4 !== 1'b1 || en4 !== 1'b0) begin
            errors++;
            $display("FAIL restart_arm: timer=%0d busy=%b en=%b, expected 0 1 0", timer4, busy4, en4);
        end
        step();
        checks++;
        if (timer4 !== 16'd0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL restart_run0: timer=%0d busy=%b, expected 0 1", timer4, busy4);
        end
        k = $urandom_range(60, 10);
        steps(k);
        sensor4 = 1'b1;
        steps(S + 1);
        checks++;
        if (en4 !== 1'b1 || timer4 !== 16'(model_result(k, 4))) begin
            errors++;
            $display("FAIL restart_result: k=%0d timer=%0d en=%b, expected timer=%0d en=1",
                     k, timer4, en4, model_result(k, 4));
        end
    endtask

    task automatic test_simultaneous();
        int unsigned k;
        bit seen_done;
        seen_done = 1'b0;
        sensor4 = 1'b0;
        steps(S + 2);
        start4 = 1'b1; step(); start4 = 1'b0; step();
        k = $urandom_range(30, 5);
        steps(k);
        sensor4 = 1'b1;
        steps(S);
        start4 = 1'b1; step(); start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || en4 !== 1'b0 || timer4 !== 16'd0 || to4 !== 1'b0) begin
            errors++;
            $display("FAIL simul_arm: busy=%b en=%b timer=%0d timeout=%b, expected 1 0 0 0",
                     busy4, en4, timer4, to4);
        end
        step();
        for (int unsigned n = 1; n <= 8; n++) begin
            step();
            if (en4 !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done || busy4 !== 1'b1 || timer4 !== 16'(model_ticks(8, 4))) begin
            errors++;
            $display("FAIL simul_run: seen_done=%b busy=%b timer=%0d, expected 0 1 %0d",
                     seen_done, busy4, timer4, model_ticks(8, 4));
        end
        sensor4 = 1'b0;
    endtask

    task automatic test_saturation();
        sensor2 = 1'b0;
        start2 = 1'b1; step(); start2 = 1'b0; step();
        for (int unsigned n = 1; n <= 131071; n++) begin
            step();
            if (n % 16384 == 0) begin
                checks++;
                if (timer2 !== 16'(model_ticks(n, 2)) || en2 !== 1'b0) begin
                    errors++;
                    $display("FAIL sat_live: n=%0d timer=%0d en=%b, expected timer=%0d en=0",
                             n, timer2, en2, model_ticks(n, 2));
                end
            end
        end
        checks++;
        if (timer2 !== 16'hFFFF || en2 !== 1'b0 || to2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_edge: timer=%h en=%b timeout=%b, expected ffff 0 0", timer2, en2, to2);
        end
        step();
        checks++;
        if (timer2 !== 16'hFFFF || en2 !== 1'b1 || to2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_done: timer=%h en=%b timeout=%b busy=%b, expected ffff 1 1 0",
                     timer2, en2, to2, busy2);
        end
        steps(10);
        checks++;
        if (timer2 !== 16'hFFFF || en2 !== 1'b1 || to2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: timer=%h en=%b timeout=%b, expected ffff 1 1", timer2, en2, to2);
        end
        start2 = 1'b1; step(); start2 = 1'b0;
        checks++;
        if (timer2 !== 16'd0 || to2 !== 1'b0 || en2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL sat_restart: timer=%0d timeout=%b en=%b busy=%b, expected 0 0 0 1",
                     timer2, to2, en2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_measurement();
        test_sensor_high();
        test_restart();
        test_simultaneous();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
